// File: rtl/div_clk_monitor.sv
// div_clk_monitor: synchronizes the divided clock, ticks on each rise, measures the rise-to-rise period
// and reports lock/error status. Define DIV_MON_TIMEOUT_EN to add the stalled-input timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | monitor disabled; counter, good count and lock cleared
// SEARCH   | waiting for a reference rise to start measuring
// MEASURE  | measuring periods, counting consecutive in-tolerance ones
// LOCKED   | period stable within tolerance
module div_clk_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int PERIOD_W    = 8,
    parameter int EXP_PERIOD  = 16,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                div_in,
    output logic                tick,
    output logic [PERIOD_W-1:0] period,
    output logic                locked,
    output logic                err,
    output logic [7:0]          err_cnt
);

    localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
    localparam logic [PERIOD_W-1:0] LO_LIM    = PERIOD_W'(EXP_PERIOD - TOL);
    localparam logic [PERIOD_W-1:0] HI_LIM    = PERIOD_W'(EXP_PERIOD + TOL);
    localparam logic [PERIOD_W-1:0] TO_CNT    = PERIOD_W'(TIMEOUT - 1);
    localparam logic [3:0]          GOOD_LOCK = 4'(LOCK_CNT);
`ifdef DIV_MON_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_MEASURE, S_LOCKED} state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     hist_q, hist_d;
    logic [PERIOD_W-1:0]      cnt_q, cnt_d;
    logic [PERIOD_W-1:0]      period_q, period_d;
    logic [3:0]               good_q, good_d;
    logic                     tick_q, tick_d;
    logic                     err_q, err_d;
    logic                     locked_q, locked_d;
    logic [7:0]               err_cnt_q, err_cnt_d;

    logic                     rise;
    logic                     active;
    logic [PERIOD_W-1:0]      meas;
    logic                     in_tol;
    logic [3:0]               good_inc;
    logic                     timeout_hit;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], div_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign active   = (state_q == S_MEASURE) || (state_q == S_LOCKED);
    // A saturated counter means the true period is unknown, so it can never be in tolerance.
    assign meas     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + PERIOD_W'(1);
    assign in_tol   = (cnt_q != CNT_MAX) && (meas >= LO_LIM) && (meas <= HI_LIM);
    assign good_inc = good_q + 4'd1;
    assign timeout_hit = TIMEOUT_EN && active && !rise && (cnt_q == TO_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_SEARCH;
                S_SEARCH:  if (rise) state_d = S_MEASURE;
                S_MEASURE: begin
                    if (rise && in_tol && good_inc == GOOD_LOCK) state_d = S_LOCKED;
                    else if (timeout_hit)                        state_d = S_SEARCH;
                end
                S_LOCKED: begin
                    if (rise && !in_tol)  state_d = S_MEASURE;
                    else if (timeout_hit) state_d = S_SEARCH;
                end
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin : outputs
        cnt_d     = cnt_q;
        good_d    = good_q;
        period_d  = period_q;
        tick_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        locked_d  = (state_d == S_LOCKED);
        if (!enable || state_q == S_IDLE) begin
            cnt_d  = '0;
            good_d = '0;
        end else if (rise) begin
            tick_d = 1'b1;
            cnt_d  = '0;
            if (active) begin
                period_d = meas;
                if (!in_tol) begin
                    err_d  = 1'b1;
                    good_d = '0;
                end else if (state_q == S_MEASURE) begin
                    good_d = good_inc;
                end
            end
        end else if (timeout_hit) begin
            err_d  = 1'b1;
            good_d = '0;
            cnt_d  = '0;
        end else if (active && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            good_q    <= '0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            good_q    <= good_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign tick    = tick_q;
    assign period  = period_q;
    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor: randomized and directed scenarios against a timestamp-based reference model.
// Honours DIV_MON_TIMEOUT_EN the same way as the design.
module tb_div_clk_monitor;

    localparam int EXP_PERIOD = 16;
    localparam int TOL        = 1;
    localparam int LOCK_CNT   = 4;
    localparam int TIMEOUT    = 64;
    localparam int PMAX       = 255;
`ifdef DIV_MON_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       div_in = 1'b0;
    logic       tick, locked, err;
    logic [7:0] period, err_cnt;

    div_clk_monitor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .div_in  (div_in),
        .tick    (tick),
        .period  (period),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: div_in samples per clk edge, plus the edge of the last accepted rise.
    int         cyc = 3;
    bit         samp [0:32767];
    int         mode;            // 0 disabled, 1 searching, 2 measuring (locked or not)
    int         good;
    int         last;
    logic       exp_tick, exp_err, exp_locked;
    logic [7:0] exp_period, exp_errs;
    bit         wave_q [$];

    logic [18:0] dut_v, exp_v;
    assign dut_v = {tick, err, locked, period, err_cnt};
    assign exp_v = {exp_tick, exp_err, exp_locked, exp_period, exp_errs};

    function automatic string show(logic [18:0] v);
        return $sformatf("tick=%b err=%b locked=%b period=%0d err_cnt=%0d", v[18], v[17], v[16], v[15:8], v[7:0]);
    endfunction

    task automatic model_reset();
        mode = 0; good = 0; last = 0;
        exp_tick = 1'b0; exp_err = 1'b0; exp_locked = 1'b0;
        exp_period = 8'd0; exp_errs = 8'd0;
        samp[cyc] = 1'b0; samp[cyc-1] = 1'b0; samp[cyc-2] = 1'b0;
    endtask

    // A rise sampled at edge k is acted upon at edge k+2 (two synchronizer stages).
    task automatic model_edge();
        bit rise, bad;
        int m;
        cyc++;
        samp[cyc] = rst_n ? div_in : 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise = samp[cyc-2] && !samp[cyc-3];
        exp_tick = 1'b0; exp_err = 1'b0; bad = 1'b0;
        if (!enable) begin
            mode = 0; good = 0; exp_locked = 1'b0;
        end else if (mode == 0) begin
            mode = 1;
        end else if (rise) begin
            exp_tick = 1'b1;
            if (mode == 1) begin
                mode = 2;
            end else begin
                m = cyc - last;
                if (m > PMAX) m = PMAX;
                exp_period = 8'(m);
                if (m < PMAX && m >= EXP_PERIOD - TOL && m <= EXP_PERIOD + TOL) begin
                    good++;
                    if (good >= LOCK_CNT) exp_locked = 1'b1;
                end else begin
                    bad = 1'b1; good = 0; exp_locked = 1'b0;
                end
            end
            last = cyc;
        end else if (TIMEOUT_ON && mode == 2 && cyc - last == TIMEOUT) begin
            bad = 1'b1; good = 0; exp_locked = 1'b0; mode = 1;
        end
        if (bad) begin
            exp_err = 1'b1;
            if (exp_errs != 8'd255) exp_errs = exp_errs + 8'd1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic add_period(int hi, int lo);
        repeat (hi) wave_q.push_back(1'b1);
        repeat (lo) wave_q.push_back(1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; div_in = 1'b0;
        repeat (3) cycle();
        vectors++;
        if (dut_v !== 19'd0) begin
            miscompares++; $display("FAIL reset_init got %s want all zero", show(dut_v));
        end
        rst_n = 1'b1; enable = 1'b1;
        wave_q.delete();
        for (int p = 0; p < 20; p++) begin
            int per;
            per = $urandom_range(6, 24);
            add_period(per / 2, per - per / 2);
        end
        while (wave_q.size() > 0) begin
            div_in = wave_q.pop_front();
            cycle();
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++; $display("FAIL reset_traffic cyc=%0d got %s want %s", cyc, show(dut_v), show(exp_v));
            end
        end
        div_in = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (dut_v !== 19'd0) begin
            miscompares++; $display("FAIL reset_async got %s want all zero", show(dut_v));
        end
        repeat (4) begin
            div_in = ~div_in;
            cycle();
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++; $display("FAIL reset_hold cyc=%0d got %s want %s", cyc, show(dut_v), show(exp_v));
            end
        end
        rst_n = 1'b1; enable = 1'b0;
        wave_q.delete();
        repeat (4) add_period(4, 4);
        while (wave_q.size() > 0) begin
            div_in = wave_q.pop_front();
            cycle();
            vectors++;
            if (dut_v !== 19'd0) begin
                miscompares++; $display("FAIL idle_disabled cyc=%0d got %s want all zero", cyc, show(dut_v));
            end
        end
    endtask

    task automatic test_lock();
        int ticks = 0;
        enable = 1'b1;
        wave_q.delete();
        repeat (8) add_period(8, 8);
        while (wave_q.size() > 0) begin
            div_in = wave_q.pop_front();
            cycle();
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++; $display("FAIL lock cyc=%0d got %s want %s", cyc, show(dut_v), show(exp_v));
            end
            if (exp_tick) begin
                ticks++;
                // first tick is the reference rise; the fifth completes the fourth measured period
                if (ticks == 4) begin
                    vectors++;
                    if (tick !== 1'b1 || locked !== 1'b0 || period !== 8'd16) begin
                        miscompares++; $display("FAIL lock_before got %s want tick=1 locked=0 period=16", show(dut_v));
                    end
                end
                if (ticks == 5) begin
                    vectors++;
                    if (tick !== 1'b1 || locked !== 1'b1 || period !== 8'd16) begin
                        miscompares++; $display("FAIL lock_fourth got %s want tick=1 locked=1 period=16", show(dut_v));
                    end
                end
            end
        end
        vectors++;
        if (locked !== 1'b1 || err_cnt !== 8'd0) begin
            miscompares++; $display("FAIL lock_final got %s want locked=1 err_cnt=0", show(dut_v));
        end
    endtask

    task automatic test_stretch();
        int ticks = 0;
        wave_q.delete();
        add_period(10, 10);
        repeat (5) add_period(8, 8);
        while (wave_q.size() > 0) begin
            div_in = wave_q.pop_front();
            cycle();
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++; $display("FAIL stretch cyc=%0d got %s want %s", cyc, show(dut_v), show(exp_v));
            end
            if (exp_tick) begin
                ticks++;
                if (ticks == 2) begin
                    vectors++;
                    if (err !== 1'b1 || locked !== 1'b0 || period !== 8'd20 || err_cnt !== 8'd1) begin
                        miscompares++; $display("FAIL stretch_err got %s want err=1 locked=0 period=20 err_cnt=1", show(dut_v));
                    end
                end
                if (ticks == 6) begin
                    vectors++;
                    if (locked !== 1'b1 || err !== 1'b0) begin
                        miscompares++; $display("FAIL stretch_relock got %s want locked=1 err=0", show(dut_v));
                    end
                end
            end
        end
    endtask

    task automatic test_tolerance();
        int ticks = 0;
        wave_q.delete();
        add_period(8, 7);
        add_period(9, 8);
        add_period(8, 8);
        add_period(7, 7);
        add_period(8, 8);
        add_period(8, 8);
        while (wave_q.size() > 0) begin
            div_in = wave_q.pop_front();
            cycle();
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++; $display("FAIL tolerance cyc=%0d got %s want %s", cyc, show(dut_v), show(exp_v));
            end
            if (exp_tick) begin
                ticks++;
                if (ticks == 2 || ticks == 3) begin
                    vectors++;
                    if (err !== 1'b0 || locked !== 1'b1 || period !== ((ticks == 2) ? 8'd15 : 8'd17)) begin
                        miscompares++; $display("FAIL tol_edge tick%0d got %s want err=0 locked=1", ticks, show(dut_v));
                    end
                end
                if (ticks == 5) begin
                    vectors++;
                    if (err !== 1'b1 || locked !== 1'b0 || period !== 8'd14 || err_cnt !== 8'd2) begin
                        miscompares++; $display("FAIL tol_short got %s want err=1 locked=0 period=14 err_cnt=2", show(dut_v));
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        int ticks = 0;
        int errs_seen = 0;
        wave_q.delete();
        add_period(300, 8);
        repeat (2) add_period(8, 8);
        while (wave_q.size() > 0) begin
            div_in = wave_q.pop_front();
            cycle();
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++; $display("FAIL stall cyc=%0d got %s want %s", cyc, show(dut_v), show(exp_v));
            end
            if (exp_err) errs_seen++;
            if (exp_tick) ticks++;
`ifdef DIV_MON_TIMEOUT_EN
            if (exp_err && errs_seen == 1) begin
                vectors++;
                if (err !== 1'b1 || locked !== 1'b0 || period !== 8'd16 || ticks != 1) begin
                    miscompares++; $display("FAIL stall_timeout got %s ticks=%0d want err=1 locked=0 period=16 ticks=1", show(dut_v), ticks);
                end
            end
            if (exp_tick && ticks == 2) begin
                vectors++;
                if (tick !== 1'b1 || err !== 1'b0 || period !== 8'd16) begin
                    miscompares++; $display("FAIL stall_research got %s want tick=1 err=0 period=16", show(dut_v));
                end
            end
`else
            if (exp_tick && ticks == 2) begin
                vectors++;
                if (err !== 1'b1 || period !== 8'd255 || locked !== 1'b0) begin
                    miscompares++; $display("FAIL stall_saturate got %s want err=1 period=255 locked=0", show(dut_v));
                end
            end
`endif
        end
    endtask

    task automatic test_enable_drop();
        int idx = 0;
        int drop_at;
        bit reenabled = 1'b0;
        bit first_checked = 1'b0;
        drop_at = 100 + $urandom_range(0, 15);
        wave_q.delete();
        repeat (12) add_period(8, 8);
        while (wave_q.size() > 0) begin
            div_in = wave_q.pop_front();
            enable = !(idx >= drop_at && idx < drop_at + 10);
            if (idx >= drop_at + 10) reenabled = 1'b1;
            cycle();
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++; $display("FAIL enable cyc=%0d got %s want %s", cyc, show(dut_v), show(exp_v));
            end
            if (idx == drop_at - 1) begin
                vectors++;
                if (locked !== 1'b1) begin
                    miscompares++; $display("FAIL enable_prelock got %s want locked=1", show(dut_v));
                end
            end
            if (idx >= drop_at && idx < drop_at + 10) begin
                vectors++;
                if (tick !== 1'b0 || locked !== 1'b0 || period !== 8'd16) begin
                    miscompares++; $display("FAIL enable_off got %s want tick=0 locked=0 period=16", show(dut_v));
                end
            end
            if (reenabled && exp_tick && !first_checked) begin
                first_checked = 1'b1;
                vectors++;
                if (tick !== 1'b1 || period !== 8'd16 || locked !== 1'b0 || err !== 1'b0) begin
                    miscompares++; $display("FAIL enable_first_tick got %s want tick=1 period=16 locked=0 err=0", show(dut_v));
                end
            end
            idx++;
        end
        enable = 1'b1;
    endtask

    task automatic test_random();
        int dis_left = 0;
        wave_q.delete();
        for (int p = 0; p < 40; p++) begin
            int sel, per, hi;
            sel = $urandom_range(0, 9);
            if (sel < 7)      per = $urandom_range(14, 18);
            else if (sel < 9) per = $urandom_range(4, 30);
            else              per = $urandom_range(40, 280);
            hi = $urandom_range(1, per - 1);
            add_period(hi, per - hi);
        end
        while (wave_q.size() > 0) begin
            div_in = wave_q.pop_front();
            if (dis_left > 0) begin
                enable = 1'b0;
                dis_left--;
            end else begin
                enable = 1'b1;
                if ($urandom_range(0, 299) == 0) dis_left = $urandom_range(1, 20);
            end
            cycle();
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++; $display("FAIL random cyc=%0d got %s want %s", cyc, show(dut_v), show(exp_v));
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_err_saturate();
        wave_q.delete();
        repeat (262) add_period(2, 2);
        while (wave_q.size() > 0) begin
            div_in = wave_q.pop_front();
            cycle();
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++; $display("FAIL err_sat cyc=%0d got %s want %s", cyc, show(dut_v), show(exp_v));
            end
        end
        vectors++;
        if (err_cnt !== 8'd255 || locked !== 1'b0) begin
            miscompares++; $display("FAIL err_sat_final got %s want err_cnt=255 locked=0", show(dut_v));
        end
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        test_reset();
        test_lock();
        test_stretch();
        test_tolerance();
        test_stall();
        test_enable_drop();
        test_random();
        test_err_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
